// File: rtl/soc_mem_arbiter.sv
// Purpose: shares one 32-bit memory port between the CPU (m0) and UART loader (m1), round-robin, one transaction in flight.
// Latency: request sampled in IDLE -> mem_valid next cycle; mem_ready -> master ready next cycle; minimum 3 cycles request-to-ready.
// Backpressure: masters hold valid until their ready pulse; a hung memory access is aborted by a watchdog with err=1.
module soc_mem_arbiter #(
    parameter int          ADDR_W   = 24,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wmask,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wmask,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic              WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             gnt;
    logic [CNT_W-1:0] wdog_cnt;

    logic pick_m1;
    logic req_any;
    logic wdog_fire;
    logic finish;

    // m1 wins when it is the only requester, or on a tie when m0 was served last.
    assign pick_m1   = m1_valid & (~m0_valid | ~last_grant);
    assign req_any   = m0_valid | m1_valid;
    assign wdog_fire = WDOG_EN & (wdog_cnt == CNT_LAST);
    assign finish    = mem_ready | wdog_fire;

    // Arbiter FSM with all master- and memory-side outputs registered.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            wdog_cnt   <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            m0_ready   <= 1'b0;
            m0_rdata   <= '0;
            m0_err     <= 1'b0;
            m1_ready   <= 1'b0;
            m1_rdata   <= '0;
            m1_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt        <= pick_m1;
                        last_grant <= pick_m1;
                        mem_valid  <= 1'b1;
                        mem_addr   <= pick_m1 ? m1_addr  : m0_addr;
                        mem_wdata  <= pick_m1 ? m1_wdata : m0_wdata;
                        mem_wmask  <= pick_m1 ? m1_wmask : m0_wmask;
                        wdog_cnt   <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // A real completion takes priority over a watchdog abort in the same cycle.
                    if (finish) begin
                        mem_valid <= 1'b0;
                        state     <= DONE;
                        if (gnt) begin
                            m1_ready <= 1'b1;
                            m1_err   <= ~mem_ready;
                            m1_rdata <= mem_ready ? mem_rdata : ERR_DATA;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_err   <= ~mem_ready;
                            m0_rdata <= mem_ready ? mem_rdata : ERR_DATA;
                        end
                    end else begin
                        wdog_cnt <= wdog_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // One-cycle pause lets the served master drop valid before re-arbitration.
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Purpose: directed bench for soc_mem_arbiter: table-driven single transactions plus hand-written multi-cycle sequences.
// Latency: drives and samples on the falling clock edge, one full cycle per DUT register stage.
// Backpressure: memory response delays come from the vector table or are held off by the sequence.
module tb_soc_mem_arbiter;

    localparam int AW = 24;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          m0_valid, m1_valid;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_wmask, m1_wmask;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    logic          m0_ready, m1_ready, m0_err, m1_err, mem_valid;
    logic [31:0]   m0_rdata, m1_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wmask;

    logic          nt_m0_ready, nt_m1_ready, nt_m0_err, nt_m1_err, nt_mem_valid;
    logic [31:0]   nt_m0_rdata, nt_m1_rdata, nt_mem_wdata;
    logic [AW-1:0] nt_mem_addr;
    logic [3:0]    nt_mem_wmask;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    soc_mem_arbiter #(.ADDR_W(AW), .TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) u_dut (
        .CLK(CLK), .RESET(RESET),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Watchdog disabled: used for the long-stall sequence.
    soc_mem_arbiter #(.ADDR_W(AW), .TIMEOUT(0), .ERR_DATA(32'hDEADBEEF)) u_dut_nt (
        .CLK(CLK), .RESET(RESET),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_ready(nt_m0_ready), .m0_rdata(nt_m0_rdata), .m0_err(nt_m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_ready(nt_m1_ready), .m1_rdata(nt_m1_rdata), .m1_err(nt_m1_err),
        .mem_valid(nt_mem_valid), .mem_addr(nt_mem_addr), .mem_wdata(nt_mem_wdata), .mem_wmask(nt_mem_wmask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic          m;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
        int            delay;
        logic [31:0]   mrd;
        logic [31:0]   exp_rd;
        logic          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_rdy(input logic m);
        return m ? m1_ready : m0_ready;
    endfunction

    function automatic logic get_err(input logic m);
        return m ? m1_err : m0_err;
    endfunction

    function automatic logic [31:0] get_rd(input logic m);
        return m ? m1_rdata : m0_rdata;
    endfunction

    task automatic drive_req(input logic m, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] wm);
        if (m) begin
            m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wmask = wm;
        end else begin
            m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wmask = wm;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    // One isolated transaction, checked at fixed cycle offsets.
    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] other_rd;
        @(negedge CLK);
        other_rd = get_rd(~v.m);
        drive_req(v.m, v.addr, v.wdata, v.wmask);
        @(negedge CLK);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(v.addr));
        chk({tag, "_mem_wdata"}, mem_wdata, v.wdata);
        chk({tag, "_mem_wmask"}, 32'(mem_wmask), 32'(v.wmask));
        for (int i = 0; i < v.delay; i++) @(negedge CLK);
        if (v.delay > 0) begin
            chk({tag, "_held_valid"}, 32'(mem_valid), 32'd1);
            chk({tag, "_held_addr"}, 32'(mem_addr), 32'(v.addr));
            chk({tag, "_early_rdy"}, 32'(get_rdy(v.m)), 32'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = v.mrd;
        @(negedge CLK);
        mem_ready = 1'b0;
        mem_rdata = 32'hFFFF0000;
        chk({tag, "_rdy"}, 32'(get_rdy(v.m)), 32'd1);
        chk({tag, "_rdata"}, get_rd(v.m), v.exp_rd);
        chk({tag, "_err"}, 32'(get_err(v.m)), 32'(v.exp_err));
        chk({tag, "_other_rdy"}, 32'(get_rdy(~v.m)), 32'd0);
        chk({tag, "_other_rdata"}, get_rd(~v.m), other_rd);
        chk({tag, "_mem_valid_drop"}, 32'(mem_valid), 32'd0);
        if (v.m) m1_valid = 1'b0; else m0_valid = 1'b0;
        @(negedge CLK);
        chk({tag, "_rdy_pulse_end"}, 32'(get_rdy(v.m)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n0, n1, busy_cnt, stable_bad, w;
        logic e;
        vec_t tv;

        //              m     addr        wdata         wmask    dly mrd           exp_rd        err
        vecs[0] = '{1'b0, 24'h000010, 32'h00000000, 4'b0000, 0, 32'h12345678, 32'h12345678, 1'b0};
        vecs[1] = '{1'b1, 24'h000400, 32'hA5A5A5A5, 4'b0011, 0, 32'h00001111, 32'h00001111, 1'b0};
        vecs[2] = '{1'b0, 24'hFFFFFF, 32'h00000001, 4'b1111, 3, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[3] = '{1'b1, 24'h000001, 32'h00000000, 4'b0000, 7, 32'h87654321, 32'h87654321, 1'b0};
        vecs[4] = '{1'b0, 24'h000002, 32'h00000000, 4'b0000, 6, 32'h00000000, 32'h00000000, 1'b0};

        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_wmask = '0; m1_wmask = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        // Reset state.
        repeat (2) @(negedge CLK);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_m0_err", 32'(m0_err), 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        RESET = 1'b1;

        // Table-driven single transactions (vec 3 hits mem_ready on the watchdog's last cycle).
        for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Contention: both masters request continuously from reset.
        do_reset();
        @(negedge CLK);
        drive_req(1'b0, 24'h000100, 32'h0, 4'b0000);
        drive_req(1'b1, 24'h000200, 32'h0, 4'b0000);
        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            e = k[0];
            w = 0;
            @(negedge CLK);
            while (!mem_valid && w < 10) begin @(negedge CLK); w++; end
            chk($sformatf("cont%0d_grant_seen", k), 32'(mem_valid), 32'd1);
            chk($sformatf("cont%0d_addr", k), 32'(mem_addr), e ? 32'h200 : 32'h100);
            mem_ready = 1'b1;
            mem_rdata = 32'(k) + 32'h100;
            @(negedge CLK);
            mem_ready = 1'b0;
            if (m0_ready) n0++;
            if (m1_ready) n1++;
            chk($sformatf("cont%0d_rdy", k), 32'(get_rdy(e)), 32'd1);
            chk($sformatf("cont%0d_rdata", k), get_rd(e), 32'(k) + 32'h100);
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        chk("cont_m0_pulses", 32'(n0), 32'd4);
        chk("cont_m1_pulses", 32'(n1), 32'd4);

        // Watchdog abort after 8 BUSY cycles, then a clean read.
        do_reset();
        @(negedge CLK);
        drive_req(1'b0, 24'h000020, 32'h0, 4'b0000);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (mem_valid) busy_cnt++;
        end
        chk("to_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("to_no_early_rdy", 32'(m0_ready), 32'd0);
        @(negedge CLK);
        chk("to_mem_valid", 32'(mem_valid), 32'd0);
        chk("to_rdy", 32'(m0_ready), 32'd1);
        chk("to_err", 32'(m0_err), 32'd1);
        chk("to_rdata", m0_rdata, 32'hDEADBEEF);
        chk("to_m1_rdy", 32'(m1_ready), 32'd0);
        m0_valid = 1'b0;
        tv = '{1'b0, 24'h000021, 32'h0, 4'b0000, 1, 32'h0000BEEF, 32'h0000BEEF, 1'b0};
        run_txn(tv, "after_to");

        // Long stall on the watchdog-less instance.
        do_reset();
        @(negedge CLK);
        drive_req(1'b1, 24'h000400, 32'hA5A5A5A5, 4'b0011);
        @(negedge CLK);
        stable_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!nt_mem_valid || nt_mem_addr != 24'h000400 || nt_mem_wdata != 32'hA5A5A5A5
                || nt_mem_wmask != 4'b0011 || nt_m1_ready) stable_bad++;
            @(negedge CLK);
        end
        chk("stall_stable_bad_cycles", 32'(stable_bad), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h55AA55AA;
        @(negedge CLK);
        mem_ready = 1'b0;
        chk("stall_rdy", 32'(nt_m1_ready), 32'd1);
        chk("stall_rdata", nt_m1_rdata, 32'h55AA55AA);
        chk("stall_mem_valid", 32'(nt_mem_valid), 32'd0);
        m1_valid = 1'b0;

        // Asynchronous reset mid-BUSY after m0 was granted.
        do_reset();
        @(negedge CLK);
        drive_req(1'b0, 24'h000030, 32'h11223344, 4'b1111);
        @(negedge CLK);
        chk("ar_pre_mem_valid", 32'(mem_valid), 32'd1);
        #2 RESET = 1'b0;
        #1;
        chk("ar_mem_valid", 32'(mem_valid), 32'd0);
        chk("ar_mem_addr", 32'(mem_addr), 32'd0);
        chk("ar_mem_wdata", mem_wdata, 32'd0);
        chk("ar_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("ar_m0_rdata", m0_rdata, 32'd0);
        m0_valid = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h99999999;
        @(negedge CLK);
        mem_ready = 1'b0;
        chk("ar_late_m0_rdy", 32'(m0_ready), 32'd0);
        chk("ar_late_m1_rdy", 32'(m1_ready), 32'd0);
        chk("ar_late_rdata", m0_rdata, 32'd0);
        drive_req(1'b0, 24'h000040, 32'h0, 4'b0000);
        drive_req(1'b1, 24'h000050, 32'h0, 4'b0000);
        @(negedge CLK);
        chk("ar_next_grant_addr", 32'(mem_addr), 32'h40);
        mem_ready = 1'b1;
        mem_rdata = 32'h0F0F0F0F;
        @(negedge CLK);
        mem_ready = 1'b0;
        chk("ar_next_m0_rdy", 32'(m0_ready), 32'd1);
        chk("ar_next_m1_rdy", 32'(m1_ready), 32'd0);
        m0_valid = 1'b0; m1_valid = 1'b0;
        repeat (4) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_mem_arbiter.md
Name: soc_mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares the SOC's single 32-bit memory port between the CPU (master 0) and the UART boot/debug loader (master 1).
- Uses round-robin fairness and allows one outstanding transaction.
- Registers all memory-side outputs.
- Has a watchdog that aborts a hung memory access and reports an error to the master that issued it.

Parameters:
- ADDR_W, 24, word-address width of both masters and the memory port
- TIMEOUT, 255, cycles to wait for mem_ready before aborting; 0 disables the watchdog
- ERR_DATA, 32'hDEADBEEF, read data returned on an aborted access

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- m0_valid  in  1  CPU request; held with its payload until m0_ready
- m0_addr  in  ADDR_W  CPU word address
- m0_wdata  in  32  CPU write data
- m0_wmask  in  4  CPU byte-write mask; 4'b0000 = read
- m0_ready  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data; valid when m0_ready=1
- m0_err  out  1  with m0_ready: access timed out
- m1_valid, m1_addr, m1_wdata, m1_wmask, m1_ready, m1_rdata, m1_err: same as the m0_* ports, for the loader
- mem_valid  out  1  memory request; held until mem_ready
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  32  registered write data
- mem_wmask  out  4  registered byte mask
- mem_ready  in  1  memory completion; one-cycle pulse
- mem_rdata  in  32  memory read data; valid with mem_ready

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; last_grant=1, so master 0 wins the first tie.
  - mem_valid=0; mem_addr, mem_wdata, mem_wmask=0.
  - m0_ready, m1_ready, m0_err, m1_err=0; m0_rdata, m1_rdata=0; watchdog counter=0.
- Reset asserted mid-transaction: the transaction is dropped and no ready pulse is issued. A late mem_ready arriving in IDLE is ignored.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any valid is high, grant one master.
  - With only one requester, that master is granted.
  - With both requesting, the master != last_grant is granted.
  - On the grant edge: copy the granted master's addr/wdata/wmask into mem_*, set mem_valid=1, update last_grant, clear the counter, go to BUSY.
  - Timing: a request sampled in IDLE at cycle N gives mem_valid=1 in cycle N+1.
- BUSY:
  - mem_valid stays 1 and mem_* stay stable.
  - On mem_ready=1 at cycle M: mem_valid=0 in M+1; the granted master's rdata is registered from mem_rdata (writes also latch it; content is don't-care); ready=1 and err=0 in M+1; go to DONE.
  - The watchdog counter increments each BUSY cycle without mem_ready. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no mem_ready, the next cycle gives mem_valid=0, rdata=ERR_DATA, ready=1, err=1, state=DONE.
  - If mem_ready and the timeout coincide, mem_ready wins (err=0).
- DONE:
  - Lasts exactly one cycle; the ready/err pulse is visible here.
  - The non-granted master's ready, err and rdata are unchanged (ready=0).
  - Next state is IDLE unconditionally. This lets the finished master drop valid, so no duplicate grant occurs.
- Latencies:
  - Minimum request-to-ready is 3 cycles (request seen cycle N, mem_ready in N+1, ready in N+2, DONE).
  - Minimum back-to-back turnaround is 1 idle-state cycle.
- Master valid changes outside IDLE are ignored until the next IDLE. A master that drops valid before its grant simply loses the request.
- Master 1 can never be starved: with continuous requests from both, grants alternate 0,1,0,1.

Test Plan:
- Single read: m0 reads addr 0x000010 while memory returns 0x12345678 one cycle after mem_valid -> mem_addr=0x000010, mem_wmask=0; m0_rdata=0x12345678, m0_ready pulses for 1 cycle; m0_err=0; m1_ready stays 0.
- Write pass-through: m1 writes 0xA5A5A5A5 with mask 4'b0011 to 0x000400 -> mem_* carry exactly these values while mem_valid=1; m1_ready pulses once.
- Contention: m0 and m1 both hold valid for 4 transactions each from reset -> grant order 0,1,0,1,... and each master receives 4 ready pulses.
- Stall: memory holds mem_ready low for 10 cycles -> mem_valid and mem_* stay stable for all 10 cycles; ready follows 1 cycle after mem_ready.
- Timeout: TIMEOUT=8, mem_ready never asserts -> mem_valid drops after 8 BUSY cycles; m0_rdata=0xDEADBEEF, m0_err=1, m0_ready=1. A subsequent normal read succeeds with err=0.
- Async reset mid-BUSY: assert RESET=0 between clock edges -> all outputs reach their reset values immediately. A late mem_ready produces no ready pulse, and the next grant goes to m0.
